// File: rtl/ucode_loader.sv
// ucode_loader: writer side of the microcode control store.
// Accepts a framed byte stream (HEADER, ADDR, COUNT, COUNT*BPW payload bytes MSB-first, CSUM),
// assembles WORD_W-bit microwords and strobes them into the control store, holding the CPU off
// while a frame is in flight.
// Optional macro UCODE_LOADER_TIMEOUT_EN: aborts a stalled frame after TIMEOUT_CYCLES idle cycles.
module ucode_loader #(
    parameter int          ADDR_W         = 8,
    parameter int          WORD_W         = 48,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int BPW = WORD_W / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    // Reject parameter sets the datapath cannot represent.
    if ((WORD_W % 8) != 0 || WORD_W < 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("ucode_loader: unsupported WORD_W/TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_PAYLOAD,
        S_WRITE,
        S_CSUM
    } state_t;

    state_t            state;
    logic [7:0]        csum;
    logic [8:0]        wcnt;
    logic [BCW-1:0]    bcnt;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] shifted;
    logic              accept;
    logic              timeout;

    assign accept  = rx_valid && rx_ready;
    assign shifted = {sreg[WORD_W-9:0], rx_data};

`ifdef UCODE_LOADER_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] idle_cnt;

    assign timeout = (state inside {S_ADDR, S_COUNT, S_PAYLOAD, S_CSUM}) && (idle_cnt == TO_LIM);

    // Inter-byte idle counter: cleared on every accepted byte, frozen during the write cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (timeout || accept || state == S_IDLE) begin
            idle_cnt <= '0;
        end else if (state != S_WRITE) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Frame parser FSM with registered handshake, write strobe and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            rx_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            csum     <= '0;
            wcnt     <= '0;
            bcnt     <= '0;
            sreg     <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (timeout) begin
                // Stalled frame: drop the partial word and release the CPU with an error.
                state    <= S_IDLE;
                rx_ready <= 1'b1;
                cpu_hold <= 1'b0;
                err      <= 1'b1;
                bcnt     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        rx_ready <= 1'b1;
                        if (accept && rx_data == HEADER) begin
                            state    <= S_ADDR;
                            cpu_hold <= 1'b1;
                            err      <= 1'b0;
                            csum     <= '0;
                        end
                    end
                    S_ADDR: begin
                        if (accept) begin
                            wr_addr <= ADDR_W'(rx_data);
                            csum    <= csum + rx_data;
                            state   <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (accept) begin
                            wcnt  <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                            csum  <= csum + rx_data;
                            bcnt  <= '0;
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (accept) begin
                            csum <= csum + rx_data;
                            sreg <= shifted;
                            if (bcnt == BCW'(BPW - 1)) begin
                                wr_data  <= shifted;
                                wr_en    <= 1'b1;
                                rx_ready <= 1'b0;
                                bcnt     <= '0;
                                state    <= S_WRITE;
                            end else begin
                                bcnt <= bcnt + BCW'(1);
                            end
                        end
                    end
                    S_WRITE: begin
                        rx_ready <= 1'b1;
                        wr_addr  <= wr_addr + ADDR_W'(1);
                        wcnt     <= wcnt - 9'd1;
                        state    <= (wcnt == 9'd1) ? S_CSUM : S_PAYLOAD;
                    end
                    S_CSUM: begin
                        if (accept) begin
                            state    <= S_IDLE;
                            cpu_hold <= 1'b0;
                            if (rx_data == csum) begin
                                done <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        rx_ready <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ucode_loader.sv
// Testbench for ucode_loader: directed frames, scoreboard of expected control-store writes.
module tb_ucode_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [47:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [55:0] exp_q[$];
    logic [55:0] exp_e;
    logic [47:0] wbuf[4];

    always #5 clk = ~clk;

    ucode_loader #(
        .ADDR_W(8),
        .WORD_W(48),
        .HEADER(8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Present one byte at a negedge and return at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Send ADDR, COUNT, payload from wbuf and checksum (optionally corrupted by +1).
    task automatic frame_body(input logic [7:0] addr, input int nw, input bit bad);
        logic [7:0] cs;
        logic [7:0] b;
        cs = addr + 8'(nw);
        send_byte(addr);
        send_byte(8'(nw));
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 6; k++) begin
                b  = wbuf[w][47 - 8*k -: 8];
                cs = cs + b;
                if (k == 5) exp_q.push_back({addr + 8'(w), wbuf[w]});
                send_byte(b);
            end
        end
        send_byte(bad ? cs + 8'd1 : cs);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (wr_en === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL wr_unexpected: observed addr %0h data %0h expected no write", wr_addr, wr_data);
                end
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(exp_e[55:48]));
                    chk("wr_data", 64'(wr_data), 64'(exp_e[47:0]));
                end
            end
            if (done === 1'b1) chk("done_err_excl", {63'd0, err}, 64'd0);
        end
    end

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        chk("rst_wr_en",    {63'd0, wr_en},    64'd0);
        chk("rst_wr_addr",  64'(wr_addr),      64'd0);
        chk("rst_wr_data",  64'(wr_data),      64'd0);
        chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
        chk("rst_done",     {63'd0, done},     64'd0);
        chk("rst_err",      {63'd0, err},      64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", {63'd0, rx_ready}, 64'd1);

        // Single-word frame, checksum 0x7B
        wbuf[0] = 48'h123456789ABC;
        send_byte(8'hA5);
        chk("t1_hold_on", {63'd0, cpu_hold}, 64'd1);
        frame_body(8'h10, 1, 1'b0);
        chk("t1_done", {63'd0, done},     64'd1);
        chk("t1_hold", {63'd0, cpu_hold}, 64'd0);
        chk("t1_err",  {63'd0, err},      64'd0);
        @(negedge clk);
        chk("t1_done_pulse", {63'd0, done}, 64'd0);

        // Two words with address wrap 0xFF -> 0x00, checksum 0x04
        wbuf[0] = 48'h000000000001;
        wbuf[1] = 48'h000000000002;
        send_byte(8'hA5);
        frame_body(8'hFF, 2, 1'b0);
        chk("t2_done", {63'd0, done}, 64'd1);
        chk("t2_addr_after", 64'(wr_addr), 64'h01);

        // Bad checksum (0x7C): word still written, sticky err, no done
        wbuf[0] = 48'h123456789ABC;
        send_byte(8'hA5);
        frame_body(8'h10, 1, 1'b1);
        chk("t3_err",  {63'd0, err},      64'd1);
        chk("t3_done", {63'd0, done},     64'd0);
        chk("t3_hold", {63'd0, cpu_hold}, 64'd0);
        repeat (5) @(negedge clk);
        chk("t3_err_sticky", {63'd0, err}, 64'd1);
        send_byte(8'hA5);
        chk("t3_err_clear", {63'd0, err},      64'd0);
        chk("t3_hold_on",   {63'd0, cpu_hold}, 64'd1);
        wbuf[0] = 48'hCAFEF00D1234;
        frame_body(8'h40, 1, 1'b0);
        chk("t3_done2", {63'd0, done}, 64'd1);

        // Junk bytes before a frame are discarded; header value inside payload is data
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        chk("t4_hold", {63'd0, cpu_hold}, 64'd0);
        chk("t4_err",  {63'd0, err},      64'd0);
        wbuf[0] = 48'hA5A5A5A5A5A5;
        send_byte(8'hA5);
        frame_body(8'hA5, 1, 1'b0);
        chk("t4_done", {63'd0, done}, 64'd1);

        // Reset after third payload byte: partial word never written
        send_byte(8'hA5);
        send_byte(8'h30);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        reset = 1'b0;
        #1;
        chk("t5_wr_en",    {63'd0, wr_en},    64'd0);
        chk("t5_wr_addr",  64'(wr_addr),      64'd0);
        chk("t5_wr_data",  64'(wr_data),      64'd0);
        chk("t5_hold",     {63'd0, cpu_hold}, 64'd0);
        chk("t5_rx_ready", {63'd0, rx_ready}, 64'd0);
        chk("t5_err",      {63'd0, err},      64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rx_ready_rel", {63'd0, rx_ready}, 64'd1);
        wbuf[0] = 48'h010203040506;
        send_byte(8'hA5);
        frame_body(8'h31, 1, 1'b0);
        chk("t5_done", {63'd0, done}, 64'd1);

        // Stall after ADDR
        send_byte(8'hA5);
        send_byte(8'h20);
        repeat (120) @(negedge clk);
`ifdef UCODE_LOADER_TIMEOUT_EN
        chk("t6_err",      {63'd0, err},      64'd1);
        chk("t6_hold",     {63'd0, cpu_hold}, 64'd0);
        chk("t6_rx_ready", {63'd0, rx_ready}, 64'd1);
`else
        chk("t6_hold",     {63'd0, cpu_hold}, 64'd1);
        chk("t6_err",      {63'd0, err},      64'd0);
        chk("t6_rx_ready", {63'd0, rx_ready}, 64'd1);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucode_loader.md
Name: ucode_loader

Overview:
- Writer side of the microcode control store: the decoder reads 48-bit microwords by 8-bit address, and this block writes them.
- Receives a framed byte stream (from the UART RX path), assembles 48-bit words MSB-first and issues write strobes into the RAM-based control store.
- Holds the CPU off while a frame is in flight and flags checksum or framing errors.

Parameters:
- ADDR_W, 8, control store address width
- WORD_W, 48, microword width; must be a multiple of 8; bytes per word BPW = WORD_W/8
- HEADER, 8'hA5, frame start byte
- TIMEOUT_CYCLES, 65535, inter-byte timeout in clk cycles; used only with the optional feature

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted on a cycle where rx_valid && rx_ready
- wr_en  out  1  one-cycle control store write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  WORD_W  write data
- cpu_hold  out  1  high from header accept until DONE/ERR is entered; CPU must not fetch
- done  out  1  one-cycle pulse when a frame completes with a good checksum
- err  out  1  sticky error; cleared when the next HEADER is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - rx_ready=0 during reset, 1 after release in IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0.
  - Byte counter, word counter and checksum are all 0.
- Frame format: HEADER, ADDR, COUNT, then COUNT*BPW payload bytes (MSB first), then CSUM.
  - COUNT=0 means 256 words.
  - CSUM = 8-bit modulo-256 sum of ADDR, COUNT and all payload bytes.
- States:
  - IDLE: rx_ready=1. HEADER byte -> ADDR, cpu_hold=1, err=0, csum=0. Any other byte is discarded; no error.
  - ADDR: on accept, wr_addr<=byte, csum+=byte -> COUNT.
  - COUNT: on accept, word counter<=byte (0 treated as 256), csum+=byte -> PAYLOAD.
  - PAYLOAD: on each accept, shift byte into the word shift register LSB end, csum+=byte. When the BPW-th byte is accepted -> WRITE.
  - WRITE: exactly one cycle.
    - rx_ready=0, wr_en=1, wr_data=assembled word, wr_addr=current address.
    - Next cycle: wr_addr increments mod 2^ADDR_W (0xFF wraps to 0x00) and word counter decrements.
    - If the counter reaches 0 -> CSUM, else -> PAYLOAD.
  - CSUM: on accept, compare byte with csum.
    - Match -> IDLE with done pulsed for 1 cycle.
    - Mismatch -> IDLE with err=1.
    - cpu_hold drops in the same cycle in both cases.
- Latency:
  - wr_en is asserted the cycle after the last byte of a word is accepted.
  - done is asserted the cycle after CSUM is accepted.
- rx_ready is 1 in every state except WRITE and reset. A byte presented during WRITE waits; it is not dropped.
- Words already written before a checksum mismatch remain in the store. err signals that the store contents are invalid.
- A HEADER value appearing inside ADDR, COUNT, PAYLOAD or CSUM is treated as data; there is no resync mid-frame.
- Reset mid-frame: immediate return to IDLE.
  - wr_en is forced to 0 asynchronously.
  - The partial word is never written.
- wr_data and wr_addr hold their last values outside WRITE.
- done and err are never both asserted in the same cycle.

Optional Feature:
- UCODE_LOADER_TIMEOUT_EN defined:
  - A 16-bit idle counter runs in ADDR, COUNT, PAYLOAD and CSUM. It resets on each accepted byte and holds in WRITE.
  - When it reaches TIMEOUT_CYCLES: -> IDLE, err=1, cpu_hold=0, the partial word is discarded.
- Undefined: no counter is present and the block waits indefinitely mid-frame.

Test Plan:
- Frame A5 10 01 12 34 56 78 9A BC 7B -> one wr_en, wr_addr=0x10, wr_data=48'h123456789ABC; done pulse; err=0; cpu_hold high from the A5 accept until done.
- Frame A5 FF 02 with words 000000000001 and 000000000002, CSUM=0x04 -> writes to 0xFF then 0x00 (wrap); done=1.
- Same single-word frame as the first scenario but CSUM=0x7C -> word written at 0x10; err=1, stays 1; no done; err clears on the next A5.
- Bytes 00 FF 5A before a valid frame -> discarded with no writes and no err; the following frame loads normally.
- Assert reset after the 3rd payload byte -> no wr_en; all outputs at reset values; a fresh frame then loads correctly.
- With UCODE_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: stall 100 cycles after ADDR -> err=1, cpu_hold=0, state IDLE. Without the macro -> still waiting and cpu_hold=1.
